// File: rtl/sync_dual_port_ram_if.sv
// rtl/sync_dual_port_ram_if.sv - write/read port bundle for sync_dual_port_ram (parity signals under SYNC_DUAL_PORT_RAM_PARITY_EN)
interface sync_dual_port_ram_if #(
   parameter int DATA_RAM_WIDTH = 32,
   parameter int ADDR_WIDTH     = 8
);
   logic                          wr_en;
   logic [ADDR_WIDTH-1:0]         wr_addr;
   logic [DATA_RAM_WIDTH-1:0]     wr_data;
   logic [DATA_RAM_WIDTH/8-1:0]   wr_be;
   logic                          rd_en;
   logic [ADDR_WIDTH-1:0]         rd_addr;
   logic [DATA_RAM_WIDTH-1:0]     rd_data;
   logic                          rd_valid;
`ifdef SYNC_DUAL_PORT_RAM_PARITY_EN
   logic                          wr_parity_inject;
   logic                          rd_parity_err;

   modport master (
      output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, wr_parity_inject,
      input  rd_data, rd_valid, rd_parity_err
   );
   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, wr_parity_inject,
      output rd_data, rd_valid, rd_parity_err
   );
`else
   modport master (
      output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      input  rd_data, rd_valid
   );
   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      output rd_data, rd_valid
   );
`endif
endinterface

// File: rtl/sync_dual_port_ram.sv
// rtl/sync_dual_port_ram.sv - byte-enable simple dual-port RAM with pipelined read; optional parity via SYNC_DUAL_PORT_RAM_PARITY_EN
module sync_dual_port_ram #(
   parameter int DATA_RAM_WIDTH = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int READ_LATENCY   = 1,
   parameter int RDW_MODE       = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   sync_dual_port_ram_if.slave bus
);
   localparam int NB    = DATA_RAM_WIDTH / 8;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int LAT   = READ_LATENCY;

   generate
      if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
         $error("sync_dual_port_ram: READ_LATENCY must be 1..4");
      end
      if (DATA_RAM_WIDTH < 8 || (DATA_RAM_WIDTH % 8) != 0) begin : g_bad_width
         $error("sync_dual_port_ram: DATA_RAM_WIDTH must be a non-zero multiple of 8");
      end
   endgenerate

   logic [DATA_RAM_WIDTH-1:0] mem_q [DEPTH];
   logic                      wr_fire;
   logic [NB-1:0]             fwd;
   logic [DATA_RAM_WIDTH-1:0] rd_word;

   // Writes are gated by rst_n so an edge that lands during reset never lands in the array.
   assign wr_fire = bus.wr_en & rst_n;

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.wr_be[i]) mem_q[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      fwd     = '0;
      rd_word = mem_q[bus.rd_addr];
      if (RDW_MODE == 1 && bus.wr_en && bus.rd_addr == bus.wr_addr) fwd = bus.wr_be;
      for (int i = 0; i < NB; i++) begin
         if (fwd[i]) rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
   end

`ifdef SYNC_DUAL_PORT_RAM_PARITY_EN
   logic [NB-1:0] par_mem_q [DEPTH];
   logic [NB-1:0] wr_par;
   logic [NB-1:0] rd_par;
   logic [NB-1:0] rd_calc;
   logic          rd_err;

   always_comb begin
      for (int i = 0; i < NB; i++) begin
         wr_par[i]  = ^bus.wr_data[8*i +: 8];
         rd_calc[i] = ^rd_word[8*i +: 8];
      end
      wr_par[0] = wr_par[0] ^ bus.wr_parity_inject;
      rd_par    = par_mem_q[bus.rd_addr];
      for (int i = 0; i < NB; i++) begin
         if (fwd[i]) rd_par[i] = wr_par[i];
      end
      rd_err = |(rd_par ^ rd_calc);
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.wr_be[i]) par_mem_q[bus.wr_addr][i] <= wr_par[i];
         end
      end
   end
`endif

   logic [DATA_RAM_WIDTH-1:0] data_q [LAT];
   logic [DATA_RAM_WIDTH-1:0] data_d [LAT];
   logic [LAT-1:0]            vld_q;
   logic [LAT-1:0]            vld_d;
`ifdef SYNC_DUAL_PORT_RAM_PARITY_EN
   logic [LAT-1:0]            err_q;
   logic [LAT-1:0]            err_d;
`endif

   // Each stage only loads when a result arrives, so the last stage holds rd_data between pulses.
   always_comb begin
      vld_d = '0;
      for (int s = 0; s < LAT; s++) data_d[s] = data_q[s];
      vld_d[0] = bus.rd_en;
      if (bus.rd_en) data_d[0] = rd_word;
      for (int s = 1; s < LAT; s++) begin
         vld_d[s] = vld_q[s-1];
         if (vld_q[s-1]) data_d[s] = data_q[s-1];
      end
`ifdef SYNC_DUAL_PORT_RAM_PARITY_EN
      err_d    = '0;
      err_d[0] = bus.rd_en & rd_err;
      for (int s = 1; s < LAT; s++) err_d[s] = vld_q[s-1] & err_q[s-1];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int s = 0; s < LAT; s++) data_q[s] <= '0;
`ifdef SYNC_DUAL_PORT_RAM_PARITY_EN
         err_q <= '0;
`endif
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
`ifdef SYNC_DUAL_PORT_RAM_PARITY_EN
         err_q  <= err_d;
`endif
      end
   end

   assign bus.rd_data  = data_q[LAT-1];
   assign bus.rd_valid = vld_q[LAT-1];
`ifdef SYNC_DUAL_PORT_RAM_PARITY_EN
   assign bus.rd_parity_err = err_q[LAT-1];
`endif

endmodule

// File: tb/tb_sync_dual_port_ram.sv
// tb/tb_sync_dual_port_ram.sv - scoreboard bench running RDW_MODE 0 and 1 instances side by side
module tb_sync_dual_port_ram;
   localparam int W   = 32;
   localparam int AW  = 4;
   localparam int NB  = W / 8;
   localparam int LAT = 2;

   typedef struct {
      logic [W-1:0] data;
      logic         err;
      int           due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   exp_t         q0[$];
   exp_t         q1[$];
   logic [W-1:0] model [1<<AW];
   logic         perr [1<<AW];
   logic [W-1:0] last0;
   logic [W-1:0] last1;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sync_dual_port_ram_if #(.DATA_RAM_WIDTH(W), .ADDR_WIDTH(AW)) bus0 ();
   sync_dual_port_ram_if #(.DATA_RAM_WIDTH(W), .ADDR_WIDTH(AW)) bus1 ();

   sync_dual_port_ram #(.DATA_RAM_WIDTH(W), .ADDR_WIDTH(AW), .READ_LATENCY(LAT), .RDW_MODE(0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   sync_dual_port_ram #(.DATA_RAM_WIDTH(W), .ADDR_WIDTH(AW), .READ_LATENCY(LAT), .RDW_MODE(1))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   task automatic advance();
      exp_t e;
      @(negedge clk);
      checks++;
      if (bus0.rd_valid) begin
         if (q0.size() == 0) begin
            failures++;
            $display("FAIL unexpected_valid0 actual=1 expected=0 cyc=%0d", cyc);
         end else begin
            e = q0.pop_front();
            last0 = e.data;
            if (bus0.rd_data !== e.data || cyc != e.due) begin
               failures++;
               $display("FAIL rd_data0 actual=%h@%0d expected=%h@%0d", bus0.rd_data, cyc, e.data, e.due);
            end
`ifdef SYNC_DUAL_PORT_RAM_PARITY_EN
            checks++;
            if (bus0.rd_parity_err !== e.err) begin
               failures++;
               $display("FAIL parity_err0 actual=%b expected=%b", bus0.rd_parity_err, e.err);
            end
`endif
         end
      end else if (bus0.rd_data !== last0) begin
         failures++;
         $display("FAIL hold0 actual=%h expected=%h", bus0.rd_data, last0);
      end
      checks++;
      if (bus1.rd_valid) begin
         if (q1.size() == 0) begin
            failures++;
            $display("FAIL unexpected_valid1 actual=1 expected=0 cyc=%0d", cyc);
         end else begin
            e = q1.pop_front();
            last1 = e.data;
            if (bus1.rd_data !== e.data || cyc != e.due) begin
               failures++;
               $display("FAIL rd_data1 actual=%h@%0d expected=%h@%0d", bus1.rd_data, cyc, e.data, e.due);
            end
`ifdef SYNC_DUAL_PORT_RAM_PARITY_EN
            checks++;
            if (bus1.rd_parity_err !== e.err) begin
               failures++;
               $display("FAIL parity_err1 actual=%b expected=%b", bus1.rd_parity_err, e.err);
            end
`endif
         end
      end else if (bus1.rd_data !== last1) begin
         failures++;
         $display("FAIL hold1 actual=%h expected=%h", bus1.rd_data, last1);
      end
   endtask

   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                        input logic [NB-1:0] be, input logic re, input logic [AW-1:0] ra,
                        input logic inj);
      exp_t e0;
      exp_t e1;
      bus0.wr_en = we; bus0.wr_addr = wa; bus0.wr_data = wd; bus0.wr_be = be;
      bus0.rd_en = re; bus0.rd_addr = ra;
      bus1.wr_en = we; bus1.wr_addr = wa; bus1.wr_data = wd; bus1.wr_be = be;
      bus1.rd_en = re; bus1.rd_addr = ra;
`ifdef SYNC_DUAL_PORT_RAM_PARITY_EN
      bus0.wr_parity_inject = inj;
      bus1.wr_parity_inject = inj;
`endif
      if (re && rst_n) begin
         e0.data = model[ra];
         e0.err  = perr[ra];
         e0.due  = cyc + LAT;
         e1      = e0;
         if (we && wa == ra) begin
            for (int i = 0; i < NB; i++) if (be[i]) e1.data[8*i +: 8] = wd[8*i +: 8];
            if (be[0]) e1.err = inj;
         end
         q0.push_back(e0);
         q1.push_back(e1);
      end
      if (we && rst_n) begin
         for (int i = 0; i < NB; i++) if (be[i]) model[wa][8*i +: 8] = wd[8*i +: 8];
         if (be[0]) perr[wa] = inj;
      end
      advance();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      last0 = '0;
      last1 = '0;
      for (int a = 0; a < (1 << AW); a++) perr[a] = 1'b0;
      idle(2);
      checks++;
      if (bus0.rd_valid !== 1'b0 || bus1.rd_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid actual=%b%b expected=00", bus0.rd_valid, bus1.rd_valid);
      end
      checks++;
      if (bus0.rd_data !== '0 || bus1.rd_data !== '0) begin
         failures++;
         $display("FAIL reset_data actual=%h/%h expected=0", bus0.rd_data, bus1.rd_data);
      end
      rst_n = 1'b1;
      idle(1);
   endtask

   task automatic test_full_write();
      drive(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, '0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
      idle(LAT + 1);
   endtask

   task automatic test_byte_enable();
      drive(1'b1, 4'd5, 32'hAAAAAAAA, 4'hF, 1'b0, '0, 1'b0);
      drive(1'b1, 4'd5, 32'h11223344, 4'h5, 1'b0, '0, 1'b0);
      checks++;
      if (model[5] !== 32'hAA22AA44) begin
         failures++;
         $display("FAIL be_model actual=%h expected=aa22aa44", model[5]);
      end
      drive(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
      drive(1'b1, 4'd5, 32'hFFFFFFFF, 4'h0, 1'b0, '0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
      idle(LAT + 1);
   endtask

   task automatic test_collision();
      drive(1'b1, 4'd7, 32'h00000000, 4'hF, 1'b0, '0, 1'b0);
      drive(1'b1, 4'd7, 32'hCAFEF00D, 4'hF, 1'b1, 4'd7, 1'b0);
      drive(1'b1, 4'd7, 32'h55667788, 4'h3, 1'b1, 4'd7, 1'b0);
      drive(1'b1, 4'd6, 32'h99999999, 4'hF, 1'b1, 4'd7, 1'b0);
      idle(LAT + 1);
   endtask

   task automatic test_back_to_back();
      for (int a = 0; a < 4; a++) drive(1'b1, a[AW-1:0], 32'h10 + a, 4'hF, 1'b0, '0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 4'd0, 1'b0);
      drive(1'b1, 4'd0, 32'hFF, 4'hF, 1'b1, 4'd1, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
      idle(LAT + 2);
   endtask

   task automatic test_reset_mid();
      drive(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      last0 = '0;
      last1 = '0;
      #1;
      checks++;
      if (bus0.rd_valid !== 1'b0 || bus1.rd_valid !== 1'b0 || bus0.rd_data !== '0 || bus1.rd_data !== '0) begin
         failures++;
         $display("FAIL mid_reset actual=%b%b %h/%h expected=00 0/0", bus0.rd_valid, bus1.rd_valid,
                  bus0.rd_data, bus1.rd_data);
      end
      drive(1'b1, 4'd2, 32'h0BADBAD0, 4'hF, 1'b1, 4'd2, 1'b0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      drive(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
      idle(LAT + 1);
   endtask

`ifdef SYNC_DUAL_PORT_RAM_PARITY_EN
   task automatic test_parity();
      drive(1'b1, 4'd9, 32'h12345678, 4'hF, 1'b0, '0, 1'b1);
      drive(1'b0, '0, '0, '0, 1'b1, 4'd9, 1'b0);
      idle(LAT + 1);
      drive(1'b1, 4'd9, 32'h12345678, 4'hF, 1'b0, '0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b1, 4'd9, 1'b0);
      idle(LAT + 1);
   endtask
`endif

   initial begin
      bus0.wr_en = 1'b0; bus0.rd_en = 1'b0;
      bus1.wr_en = 1'b0; bus1.rd_en = 1'b0;
      test_reset();
      test_full_write();
      test_byte_enable();
      test_collision();
      test_back_to_back();
      test_reset_mid();
`ifdef SYNC_DUAL_PORT_RAM_PARITY_EN
      test_parity();
`endif
      idle(LAT + 2);
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d/%0d expected=0/0", q0.size(), q1.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
